// File: rtl/dsp_route_sequencer_pkg.sv
// Shared definitions for the routing-table sequencer: FSM encoding, host
// register offsets, router sub-addresses and default sizes.
package dsp_route_sequencer_pkg;

  localparam int SLOTS_DEF       = 10;
  localparam int LOG_MODULES_DEF = 4;
  localparam int TIMEOUT_DEF     = 15;

  localparam logic [15:0] REG_CTRL          = 16'h0000;
  localparam logic [15:0] REG_STATUS        = 16'h0004;
  localparam logic [15:0] REG_MASK          = 16'h0008;
  localparam logic [15:0] TABLE_BASE        = 16'h0100;
  localparam logic [15:0] TABLE_BANK_STRIDE = 16'h0040;
  localparam logic [15:0] TABLE_SLOT_STRIDE = 16'h0004;
  localparam logic [15:0] TABLE_END         = TABLE_BASE + 16'd2 * TABLE_BANK_STRIDE;

  localparam logic [31:0] SUB_IN_SEL  = 32'h0000_0000;
  localparam logic [31:0] SUB_OUT_SEL = 32'h0000_0004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_ISSUE_IN,
    ST_WAIT_IN,
    ST_ISSUE_OUT,
    ST_WAIT_OUT,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // A table address is word aligned and falls inside the two-bank window.
  function automatic logic is_table_addr(input logic [15:0] a);
    return (a >= TABLE_BASE) && (a < TABLE_END) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dsp_route_sequencer_pick.sv
// route_priority_pick: combinational lowest-set-bit encoder used to choose
// the next pending slot.
module route_priority_pick #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downwards so the lowest set bit is the last one assigned.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/dsp_route_sequencer.sv
// Double-buffered routing-table controller: host register file, two table
// banks and a sequencer that writes the selected bank into the router.
module dsp_route_sequencer
  import dsp_route_sequencer_pkg::*;
#(
  parameter int SLOTS       = SLOTS_DEF,
  parameter int LOG_MODULES = LOG_MODULES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic        trig_i,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wen,
  input  logic        m_ack,
  input  logic        m_err,
  output logic        busy_o,
  output logic        done_o
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOTS-1:0]  pending_q, pending_d;
  logic [SLOTS-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              arm_q, arm_d;
  logic              bank_q, bank_d;
  logic              run_bank_q, run_bank_d;
  logic              active_bank_q, active_bank_d;
  logic              err_q, err_d;
  logic              trig_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;

  logic [LOG_MODULES-1:0] in_sel_q  [2][SLOTS];
  logic [1:0]             out_sel_q [2][SLOTS];

  logic              busy;
  logic              wr_ctrl, wr_status, wr_mask;
  logic              start_req, trig_launch, launch;
  logic [15:0]       tbl_off;
  logic              tbl_bank;
  logic [3:0]        tbl_slot_raw;
  logic [SLOT_W-1:0] tbl_slot;
  logic              tbl_valid, tbl_we;
  logic [SLOT_W-1:0] pick_idx;
  logic              pick_valid;
  logic [LOG_MODULES-1:0] run_in_sel;
  logic [1:0]             run_out_sel;

  route_priority_pick #(
    .N (SLOTS),
    .W (SLOT_W)
  ) u_pick (
    .req_i   (pending_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign busy = (state_q != ST_IDLE);

  // Host address decode; a 16-entry slot window per bank, only SLOTS of them backed.
  assign wr_ctrl      = wen && (addr == REG_CTRL);
  assign wr_status    = wen && (addr == REG_STATUS);
  assign wr_mask      = wen && (addr == REG_MASK);
  assign tbl_off      = addr - TABLE_BASE;
  assign tbl_bank     = tbl_off[6];
  assign tbl_slot_raw = tbl_off[5:2];
  assign tbl_slot     = tbl_slot_raw[SLOT_W-1:0];
  assign tbl_valid    = is_table_addr(addr) && (int'(tbl_slot_raw) < SLOTS);
  // The bank currently being applied is frozen until the sequence ends.
  assign tbl_we       = wen && tbl_valid && !(busy && (tbl_bank == run_bank_q));

  assign run_in_sel  = in_sel_q[run_bank_q][slot_q];
  assign run_out_sel = out_sel_q[run_bank_q][slot_q];

  always_comb begin
    arm_d  = arm_q;
    bank_d = bank_q;
    mask_d = mask_q;
    if (wr_ctrl) begin
      arm_d  = wdata[1];
      bank_d = wdata[2];
    end
    if (wr_mask) mask_d = wdata[SLOTS-1:0];
    start_req   = wr_ctrl && wdata[0];
    trig_launch = trig_i && !trig_q && arm_q;
    launch      = !busy && (start_req || trig_launch);
    if (launch && trig_launch) arm_d = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    run_bank_d    = run_bank_q;
    active_bank_d = active_bank_q;
    err_d         = err_q;
    if (wr_status && wdata[1]) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          run_bank_d = bank_d;
          pending_d  = mask_d;
          state_d    = ST_PICK;
        end
      end
      ST_PICK: begin
        if (pick_valid) begin
          slot_d  = pick_idx;
          state_d = ST_ISSUE_IN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE_IN: begin
        cnt_d   = '0;
        state_d = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (m_err) state_d = ST_ERROR;
        else if (m_ack) state_d = ST_ISSUE_OUT;
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = ST_ERROR;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_ISSUE_OUT: begin
        cnt_d   = '0;
        state_d = ST_WAIT_OUT;
      end
      ST_WAIT_OUT: begin
        if (m_err) begin
          state_d = ST_ERROR;
        end else if (m_ack) begin
          pending_d[slot_q] = 1'b0;
          state_d           = ST_PICK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        active_bank_d = run_bank_q;
        state_d       = ST_IDLE;
      end
      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    ack_d   = wen || ren;
    if (ren) begin
      if (addr == REG_CTRL) begin
        rdata_d[1] = arm_q;
        rdata_d[2] = bank_q;
      end else if (addr == REG_STATUS) begin
        rdata_d[0] = busy;
        rdata_d[1] = err_q;
        rdata_d[2] = active_bank_q;
      end else if (addr == REG_MASK) begin
        rdata_d[SLOTS-1:0] = mask_q;
      end else if (tbl_valid) begin
        rdata_d[LOG_MODULES-1:0] = in_sel_q[tbl_bank][tbl_slot];
        rdata_d[5:4]             = out_sel_q[tbl_bank][tbl_slot];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      arm_q         <= 1'b0;
      bank_q        <= 1'b0;
      run_bank_q    <= 1'b0;
      active_bank_q <= 1'b0;
      err_q         <= 1'b0;
      trig_q        <= 1'b0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      arm_q         <= arm_d;
      bank_q        <= bank_d;
      run_bank_q    <= run_bank_d;
      active_bank_q <= active_bank_d;
      err_q         <= err_d;
      trig_q        <= trig_i;
      rdata_q       <= rdata_d;
      ack_q         <= ack_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SLOTS; s++) begin
          in_sel_q[b][s]  <= '0;
          out_sel_q[b][s] <= '0;
        end
      end
    end else if (tbl_we) begin
      in_sel_q[tbl_bank][tbl_slot]  <= wdata[LOG_MODULES-1:0];
      out_sel_q[tbl_bank][tbl_slot] <= wdata[5:4];
    end
  end

  assign rdata  = rdata_q;
  assign ack    = ack_q;
  assign busy_o = busy;
  assign done_o = (state_q == ST_DONE);
  assign m_wen  = (state_q == ST_ISSUE_IN) || (state_q == ST_ISSUE_OUT);

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    if (state_q == ST_ISSUE_IN) begin
      m_addr  = (32'(slot_q) << 16) | SUB_IN_SEL;
      m_wdata = 32'(run_in_sel);
    end else if (state_q == ST_ISSUE_OUT) begin
      m_addr  = (32'(slot_q) << 16) | SUB_OUT_SEL;
      m_wdata = 32'(run_out_sel);
    end
  end

endmodule

// File: tb/tb_dsp_route_sequencer.sv
// Scoreboard bench for dsp_route_sequencer: expected router writes are queued
// at launch and consumed by a 1-cycle-ack router model.
module tb_dsp_route_sequencer;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        wen, ren;
  logic [31:0] rdata;
  logic        ack;
  logic        trig_i;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic        m_ack = 1'b0;
  logic        m_err;
  logic        busy_o, done_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } rt_wr_t;

  rt_wr_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     wr_cyc = 0;
  int     wen_cnt = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  logic   ack_en = 1'b1;
  logic   ack_pend = 1'b0;

  dsp_route_sequencer dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .addr    (addr),
    .wdata   (wdata),
    .wen     (wen),
    .ren     (ren),
    .rdata   (rdata),
    .ack     (ack),
    .trig_i  (trig_i),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wen   (m_wen),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Router model: every m_wen is scored and acked one cycle later.
  always @(negedge clk) begin
    rt_wr_t e;
    m_ack = ack_pend;
    ack_pend = 1'b0;
    if (rstn_i && m_wen) begin
      wen_cnt++;
      $display("router wr addr=0x%05h data=%0d", m_addr, m_wdata);
      check("rt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rt_addr", m_addr, e.a);
        check("rt_data", m_wdata, e.d);
      end
      ack_pend = ack_en;
    end
  end

  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1'b1; wr_cyc = cyc;
    @(negedge clk);
    wen = 1'b0;
    check("wr_ack", 32'(ack), 32'd1);
    $display("host wr addr=0x%03h data=0x%0h", a, d);
  endtask

  task automatic check_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check(tag, rdata, exp);
    $display("host rd addr=0x%03h data=0x%0h", a, rdata);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    rt_wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int base, input int launch, input int lat);
    for (int i = 0; i < 300 && done_cnt == base; i++) @(negedge clk);
    check({tag, "_done"}, 32'(done_cnt - base), 32'd1);
    if (done_cnt != base) check({tag, "_lat"}, 32'(done_cyc - launch), 32'(lat));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base, launch, wbase, i;
    rstn_i = 1'b0; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
    trig_i = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_wen", 32'(m_wen), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    rstn_i = 1'b1;
    check_read("rst_ctrl", 16'h000, 32'h0);
    check_read("rst_status", 16'h004, 32'h0);
    check_read("rst_mask", 16'h008, 32'h0);
    check_read("rst_table", 16'h100, 32'h0);

    // Bank0 slots 0 and 8; MASK bits above SLOTS must be dropped.
    host_write(16'h100, 32'h0A);
    host_write(16'h120, 32'h2B);
    host_write(16'h128, 32'h3F);
    check_read("tbl_slot10", 16'h128, 32'h0);
    check_read("tbl_slot8", 16'h120, 32'h2B);
    host_write(16'h008, 32'hFD01);
    check_read("mask_rb", 16'h008, 32'h101);
    push_exp(32'h00000, 32'd10); push_exp(32'h00004, 32'd0);
    push_exp(32'h80000, 32'd11); push_exp(32'h80004, 32'd2);
    base = done_cnt;
    host_write(16'h000, 32'h1);
    launch = wr_cyc;
    wait_done("seq2", base, launch, 12);
    check_read("seq2_status", 16'h004, 32'h0);

    // Armed trigger from bank1, one-shot.
    host_write(16'h148, 32'h15);
    host_write(16'h008, 32'h4);
    host_write(16'h000, 32'h6);
    push_exp(32'h20000, 32'd5); push_exp(32'h20004, 32'd1);
    base = done_cnt;
    @(negedge clk); trig_i = 1'b1; launch = cyc;
    @(negedge clk); trig_i = 1'b0;
    wait_done("trig", base, launch, 7);
    check_read("trig_ctrl", 16'h000, 32'h4);
    check_read("trig_status", 16'h004, 32'h4);
    base = done_cnt; wbase = wen_cnt;
    @(negedge clk); trig_i = 1'b1;
    @(negedge clk); trig_i = 1'b0;
    repeat (20) @(negedge clk);
    check("trig2_no_done", 32'(done_cnt - base), 32'd0);
    check("trig2_no_wen", 32'(wen_cnt - wbase), 32'd0);

    // Router never acks: 15 wait cycles then ERROR.
    ack_en = 1'b0;
    host_write(16'h008, 32'h1);
    push_exp(32'h00000, 32'd10);
    base = done_cnt;
    host_write(16'h000, 32'h1);
    launch = wr_cyc;
    for (i = 0; i < 100 && busy_o; i++) @(negedge clk);
    check("to_idle_lat", 32'(cyc - launch), 32'd19);
    check("to_no_done", 32'(done_cnt - base), 32'd0);
    check("to_sb_empty", 32'(exp_q.size()), 32'd0);
    check_read("to_status", 16'h004, 32'h6);
    host_write(16'h004, 32'h2);
    check_read("to_status_clr", 16'h004, 32'h4);
    ack_en = 1'b1;

    // Table writes and START during a bank0 run.
    host_write(16'h008, 32'h101);
    push_exp(32'h00000, 32'd10); push_exp(32'h00004, 32'd0);
    push_exp(32'h80000, 32'd11); push_exp(32'h80004, 32'd2);
    base = done_cnt;
    host_write(16'h000, 32'h1);
    launch = wr_cyc;
    host_write(16'h100, 32'h3F);
    host_write(16'h140, 32'h27);
    host_write(16'h000, 32'h1);
    wait_done("busy", base, launch, 12);
    repeat (20) @(negedge clk);
    check("busy_one_done", 32'(done_cnt - base), 32'd1);
    check_read("busy_b0_rb", 16'h100, 32'h0A);
    check_read("busy_b1_rb", 16'h140, 32'h27);
    check_read("busy_status", 16'h004, 32'h0);

    // Empty mask.
    host_write(16'h008, 32'h0);
    base = done_cnt; wbase = wen_cnt;
    host_write(16'h000, 32'h1);
    launch = wr_cyc;
    wait_done("mask0", base, launch, 2);
    check("mask0_no_wen", 32'(wen_cnt - wbase), 32'd0);

    // Reset during WAIT_OUT of a bank1 run with ARM set.
    host_write(16'h008, 32'h1);
    push_exp(32'h00000, 32'd7); push_exp(32'h00004, 32'd2);
    host_write(16'h000, 32'h7);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("rst2_m_wen", 32'(m_wen), 32'd0);
    check("rst2_busy", 32'(busy_o), 32'd0);
    check("rst2_done", 32'(done_o), 32'd0);
    check("rst2_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    check_read("rst2_ctrl", 16'h000, 32'h0);
    check_read("rst2_status", 16'h004, 32'h0);
    check_read("rst2_mask", 16'h008, 32'h0);
    check_read("rst2_tbl_b0", 16'h100, 32'h0);
    check_read("rst2_tbl_b1", 16'h140, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
